// File: rtl/relu_pool_stage_if.sv
//------------------------------------------------------------------------------
// relu_pool_stage_if
//
// Streaming bus between the convolution output FIFO and the ReLU/pool stage.
// It carries one psum per valid_in cycle into the stage, and one pooled value
// per valid_out pulse out of it. There is no backpressure.
//
// Signals:
//   data_in     psum value, two's complement, raster order
//   valid_in    data_in valid this cycle
//   data_out    pooled unsigned value, held between pulses
//   valid_out   one-cycle pulse per completed 2x2 window
//   frame_done  one-cycle pulse alongside the last valid_out of a frame
//
// Modports:
//   master  producer side: drives the psum stream, observes the pooled stream
//   slave   the pooling stage itself
//------------------------------------------------------------------------------
interface relu_pool_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [OUT_WIDTH-1:0]  data_out;
    logic                  valid_out;
    logic                  frame_done;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/relu_pool_stage.sv
//------------------------------------------------------------------------------
// relu_pool_stage
//
// Post-processing stage for the raster-ordered psum stream. Each accepted
// sample goes through three steps:
//   1. ReLU: negative values become zero.
//   2. Requantization: a logical right shift by SHIFT, then unsigned
//      saturation to OUT_WIDTH bits.
//   3. 2x2 stride-2 max pooling. A horizontal pair register holds the
//      even-column value. A half-width line buffer holds the pair maxima of
//      each even row until the odd row below completes the window.
// One pooled value is emitted per window. frame_done marks the last window of
// each feature map.
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   clr      synchronous frame restart, same effect as rst
//   pix_bus  relu_pool_stage_if slave: data_in/valid_in in,
//            data_out/valid_out/frame_done out (all outputs registered)
//------------------------------------------------------------------------------
module relu_pool_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 2,
    parameter int FM_WIDTH   = 8,
    parameter int FM_HEIGHT  = 8,
    parameter int COL_BITS   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    relu_pool_stage_if.slave pix_bus
);

    localparam int LB_DEPTH = FM_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_BITS-1:0]   LAST_COL  = COL_BITS'(FM_WIDTH - 1);
    localparam logic [COL_BITS-1:0]   LAST_ROW  = COL_BITS'(FM_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_LIMIT = DATA_WIDTH'({OUT_WIDTH{1'b1}});

    // Raster position of the next sample to be accepted.
    logic [COL_BITS-1:0]  col_q, col_d;
    logic [COL_BITS-1:0]  row_q, row_d;

    // Requantized even-column value that waits for its odd-column partner.
    logic [OUT_WIDTH-1:0] h_q, h_d;

    // Registered outputs.
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 frame_done_q, frame_done_d;

    // Line buffer holding one pair maximum per column pair of an even row.
    logic [OUT_WIDTH-1:0] lb_q [LB_DEPTH];
    logic [LB_AW-1:0]     lb_idx;
    logic                 lb_we;
    logic [OUT_WIDTH-1:0] lb_rd;

    logic                 restart;
    logic                 accept;
    logic [DATA_WIDTH-1:0] relu_val;
    logic [DATA_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0] q_val;
    logic [OUT_WIDTH-1:0] hmax;
    logic [OUT_WIDTH-1:0] pool_max;

    // A sample presented together with rst/clr is dropped. Restart wins.
    assign restart = rst | clr;
    assign accept  = pix_bus.valid_in & ~restart;

    //--------------------------------------------------------------------------
    // Element transform: ReLU, logical shift, then unsigned saturation.
    // Once ReLU has cleared negatives, the shift operates on a non-negative
    // value, so a plain logical shift is exact.
    //--------------------------------------------------------------------------
    always_comb begin
        relu_val = pix_bus.data_in[DATA_WIDTH-1] ? '0 : pix_bus.data_in;
        shifted  = relu_val >> SHIFT;
        q_val    = (shifted > SAT_LIMIT) ? '1 : shifted[OUT_WIDTH-1:0];
    end

    //--------------------------------------------------------------------------
    // Pooling datapath. Odd columns close a horizontal pair. The line buffer
    // entry for that column pair is shared by the even row, which writes it,
    // and the odd row below, which reads it.
    //--------------------------------------------------------------------------
    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rd    = lb_q[lb_idx];
    assign hmax     = (h_q > q_val) ? h_q : q_val;
    assign pool_max = (lb_rd > hmax) ? lb_rd : hmax;

    //--------------------------------------------------------------------------
    // Next-state logic.
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (accept) begin
            if (!col_q[0]) begin
                h_d = q_val;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_out_d   = pool_max;
                valid_out_d  = 1'b1;
                frame_done_d = (row_q == LAST_ROW) && (col_q == LAST_COL);
            end

            // Raster counters. The frame wraps straight into the next one.
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // State and output registers.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here, so every register samples the
        // pre-edge values no matter how the statements are ordered.
        if (restart) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the line buffer has no reset. Every entry is written on an even
    // row before the odd row reads it, so its power-up contents never reach
    // the output. Leaving the reset off keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= hmax;
        end
    end

    assign pix_bus.data_out   = data_out_q;
    assign pix_bus.valid_out  = valid_out_q;
    assign pix_bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_pool_stage.sv
//------------------------------------------------------------------------------
// tb_relu_pool_stage
//
// Drives two instances of relu_pool_stage: a 4x2 map and an 8x2 map. The
// reference model stores each frame as an array of requantized pixels. Each
// time the bottom-right pixel of a 2x2 window arrives, the model takes the
// max of the four pixels and queues the expected result. Observed outputs are
// checked for value, frame_done and the exact edge on which they appear.
//------------------------------------------------------------------------------
module tb_relu_pool_stage;

    localparam int W0 = 4;
    localparam int H0 = 2;
    localparam int W1 = 8;
    localparam int H1 = 2;

    typedef struct {
        int val;
        int done;
        int due;
    } exp_t;

    typedef struct {
        int val;
        int done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    relu_pool_stage_if #(.DATA_WIDTH(16), .OUT_WIDTH(8)) bus4 ();
    relu_pool_stage_if #(.DATA_WIDTH(16), .OUT_WIDTH(8)) bus8 ();

    relu_pool_stage #(
        .DATA_WIDTH(16), .OUT_WIDTH(8), .SHIFT(2),
        .FM_WIDTH(W0), .FM_HEIGHT(H0), .COL_BITS(4)
    ) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .pix_bus(bus4)
    );

    relu_pool_stage #(
        .DATA_WIDTH(16), .OUT_WIDTH(8), .SHIFT(2),
        .FM_WIDTH(W1), .FM_HEIGHT(H1), .COL_BITS(4)
    ) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .pix_bus(bus8)
    );

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    obs_t obs_q0[$];
    obs_t obs_q1[$];
    int   pix[2][16];
    int   idx[2];
    int   last_data[2];
    int   edge_cnt = 0;
    bit   rst_edge = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference element transform: ReLU, divide by 4, clamp to 255.
    function automatic int xform(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) s = 0;
        s = s / 4;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic int fw(input int sel);
        return (sel != 0) ? W1 : W0;
    endfunction

    function automatic int fh(input int sel);
        return (sel != 0) ? H1 : H0;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Records one accepted sample. Queues an expected output when the sample
    // completes a 2x2 window.
    task automatic model_accept(input int sel, input logic [15:0] v, input int due);
        int   w;
        int   h;
        int   k;
        int   r;
        int   c;
        exp_t e;
        w = fw(sel);
        h = fh(sel);
        k = idx[sel];
        r = k / w;
        c = k % w;
        pix[sel][k] = xform(v);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.val  = max2(max2(pix[sel][(r-1)*w + c-1], pix[sel][(r-1)*w + c]),
                          max2(pix[sel][r*w + c-1], pix[sel][k]));
            e.done = (k == w*h - 1) ? 1 : 0;
            e.due  = due;
            if (sel != 0) exp_q1.push_back(e);
            else          exp_q0.push_back(e);
        end
        idx[sel] = (k + 1) % (w*h);
    endtask

    task automatic set_bus(input int sel, input logic [15:0] v);
        bus4.valid_in = 1'b0;
        bus8.valid_in = 1'b0;
        if (sel != 0) begin
            bus8.data_in  = v;
            bus8.valid_in = 1'b1;
        end else begin
            bus4.data_in  = v;
            bus4.valid_in = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus4.valid_in = 1'b0;
            bus8.valid_in = 1'b0;
        end
    endtask

    // Presents one sample, optionally preceded by 0..max_gap bubble cycles.
    // The sample is accepted on the next rising edge.
    task automatic send(input int sel, input logic [15:0] v, input int max_gap);
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        @(posedge clk);
        #1;
        set_bus(sel, v);
        model_accept(sel, v, edge_cnt + 1);
    endtask

    // One cycle of rst (or clr), optionally with a sample presented at the
    // same time. That sample must be dropped.
    task automatic do_reset(input bit use_clr, input bit with_sample, input int sel,
                            input logic [15:0] v);
        @(posedge clk);
        #1;
        if (use_clr) clr = 1'b1;
        else         rst = 1'b1;
        if (with_sample) begin
            set_bus(sel, v);
        end else begin
            bus4.valid_in = 1'b0;
            bus8.valid_in = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr = 1'b0;
        bus4.valid_in = 1'b0;
        bus8.valid_in = 1'b0;
        idx[0] = 0;
        idx[1] = 0;
    endtask

    task automatic clear_obs();
        obs_q0.delete();
        obs_q1.delete();
    endtask

    task automatic take_obs(input int sel, output int v, output int d);
        obs_t o;
        v = -1;
        d = -1;
        if (sel != 0) begin
            if (obs_q1.size() > 0) begin
                o = obs_q1.pop_front();
                v = o.val;
                d = o.done;
            end
        end else begin
            if (obs_q0.size() > 0) begin
                o = obs_q0.pop_front();
                v = o.val;
                d = o.done;
            end
        end
    endtask

    // Per-cycle output check against the model queue for one DUT.
    task automatic mon(input int sel, input logic [7:0] d, input logic v, input logic fd);
        exp_t  e;
        obs_t  o;
        bit    have;
        string dn;
        dn   = (sel != 0) ? "dut8" : "dut4";
        have = (sel != 0) ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
        if (have) e = (sel != 0) ? exp_q1[0] : exp_q0[0];
        if (rst_edge) begin
            check({dn, "_rst_data"},  int'(d),  0);
            check({dn, "_rst_valid"}, int'(v),  0);
            check({dn, "_rst_done"},  int'(fd), 0);
            last_data[sel] = 0;
        end else if (v) begin
            o.val  = int'(d);
            o.done = int'(fd);
            if (sel != 0) obs_q1.push_back(o);
            else          obs_q0.push_back(o);
            if (!have) begin
                check({dn, "_unexpected_out"}, 1, 0);
            end else begin
                if (sel != 0) void'(exp_q1.pop_front());
                else          void'(exp_q0.pop_front());
                check({dn, "_out_edge"}, edge_cnt, e.due);
                check({dn, "_out_data"}, int'(d), e.val);
                check({dn, "_out_done"}, int'(fd), e.done);
                last_data[sel] = e.val;
            end
        end else begin
            check({dn, "_idle_done"}, int'(fd), 0);
            check({dn, "_hold_data"}, int'(d), last_data[sel]);
            if (have && (e.due <= edge_cnt)) begin
                check({dn, "_missing_out"}, 0, 1);
                if (sel != 0) void'(exp_q1.pop_front());
                else          void'(exp_q0.pop_front());
            end
        end
    endtask

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_edge <= rst | clr;
    end

    always @(negedge clk) begin
        mon(0, bus4.data_out, bus4.valid_out, bus4.frame_done);
        mon(1, bus8.data_out, bus8.valid_out, bus8.frame_done);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scenario-1 stream: the first window pools to 5, the second saturates to 255.
    int s1[8] = '{4, -8, 12, 3, 20, 1, -5, 1100};

    initial begin
        int ov;
        int od;
        int w8row0[8];
        int w8row1[8];
        int rv;

        bus4.data_in  = '0;
        bus4.valid_in = 1'b0;
        bus8.data_in  = '0;
        bus8.valid_in = 1'b0;
        idx[0] = 0;
        idx[1] = 0;
        last_data[0] = 0;
        last_data[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic window and saturation.
        clear_obs();
        for (int i = 0; i < 8; i++) send(0, 16'(s1[i]), 0);
        idle(4);
        take_obs(0, ov, od); check("s1_out0", ov, 5);   check("s1_done0", od, 0);
        take_obs(0, ov, od); check("s1_out1", ov, 255); check("s1_done1", od, 1);
        check("s1_count", obs_q0.size(), 0);

        // ReLU only: every sample negative.
        clear_obs();
        send(0, 16'(-1), 0);
        send(0, 16'(-32768), 0);
        for (int i = 0; i < 6; i++) send(0, 16'(-int'($urandom_range(1, 32768))), 0);
        idle(4);
        take_obs(0, ov, od); check("neg_out0", ov, 0); check("neg_done0", od, 0);
        take_obs(0, ov, od); check("neg_out1", ov, 0); check("neg_done1", od, 1);

        // Gapped input.
        clear_obs();
        for (int i = 0; i < 8; i++) send(0, 16'(s1[i]), 5);
        idle(4);
        take_obs(0, ov, od); check("gap_out0", ov, 5);
        take_obs(0, ov, od); check("gap_out1", ov, 255); check("gap_done1", od, 1);

        // Mid-frame rst, then clr, then clr with a sample presented alongside it.
        for (int m = 0; m < 3; m++) begin
            clear_obs();
            for (int i = 0; i < 5; i++) send(0, 16'(s1[i]), 0);
            do_reset(m != 0, m == 2, 0, 16'(1100));
            for (int i = 0; i < 8; i++) send(0, 16'(s1[i]), 0);
            idle(4);
            take_obs(0, ov, od); check("abort_out0", ov, 5);
            take_obs(0, ov, od); check("abort_out1", ov, 255); check("abort_done1", od, 1);
            check("abort_count", obs_q0.size(), 0);
        end

        // Back-to-back frames.
        clear_obs();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) send(0, 16'(s1[i]), 0);
        idle(4);
        for (int f = 0; f < 2; f++) begin
            take_obs(0, ov, od); check("b2b_out_a", ov, 5);   check("b2b_done_a", od, 0);
            take_obs(0, ov, od); check("b2b_out_b", ov, 255); check("b2b_done_b", od, 1);
        end

        // Tie and boundary values on the 8-wide map.
        clear_obs();
        w8row0 = '{1023, 1023, 1024, 1024, 3, 3, 0, 0};
        w8row1 = '{1020, 1022, 1024, 1024, 3, 3, 0, 0};
        w8row0[6] = int'($urandom_range(0, 4000));
        w8row0[7] = int'($urandom_range(0, 4000));
        w8row1[6] = int'($urandom_range(0, 4000));
        w8row1[7] = int'($urandom_range(0, 4000));
        for (int i = 0; i < 8; i++) send(1, 16'(w8row0[i]), 0);
        for (int i = 0; i < 8; i++) send(1, 16'(w8row1[i]), 0);
        idle(4);
        take_obs(1, ov, od); check("w8_tie", ov, 255);
        take_obs(1, ov, od); check("w8_sat", ov, 255);
        take_obs(1, ov, od); check("w8_small", ov, 0);   check("w8_small_done", od, 0);
        take_obs(1, ov, od); check("w8_last_done", od, 1);

        // Random frames on both maps, one of them cut short by clr.
        for (int f = 0; f < 8; f++) begin
            int sel;
            int n;
            sel = f % 2;
            n   = fw(sel) * fh(sel);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       rv = -int'($urandom_range(1, 32768));
                    1:       rv = int'($urandom_range(0, 1023));
                    2:       rv = int'($urandom_range(1016, 1032));
                    default: rv = int'($urandom_range(0, 65535));
                endcase
                send(sel, 16'(rv), 3);
                if (f == 5 && i == n/2) do_reset(1'b1, 1'b0, 0, 16'(0));
            end
            idle(3);
        end
        if (idx[1] != 0) begin
            for (int i = idx[1]; i < W1*H1; i++) send(1, 16'(int'($urandom_range(0, 2000))), 0);
        end
        idle(5);
        clear_obs();

        check("drain_dut4", exp_q0.size(), 0);
        check("drain_dut8", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
